// File: rtl/dp_mem_be.sv
// Simple dual-port RAM: one write port with per-byte enables, one read port with read enable and valid flag.
// Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); one read per cycle, no bubbles.
// No backpressure: every cycle with rd_en=1 is accepted, and every cycle with wr_en=1 is written.
module dp_mem_be #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int BYTE_W   = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [ADDR_W-1:0]          wr_adr,
  input  logic                       wr_en,
  input  logic [DATA_W/BYTE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0]          rd_adr,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  // Storage is deliberately not reset: contents survive reset and start undefined.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              wr_go;     // a write that actually lands (reset blocks it)
  logic              same_adr;  // read and write target the same word this cycle
  logic [DATA_W-1:0] rd_word;   // raw array read, pre-write contents
  logic [DATA_W-1:0] rd_next;   // word captured into stage 1 after the RDW policy

  logic              s1_vld;
  logic [DATA_W-1:0] s1_dat;

  assign wr_go    = wr_en & ~reset;
  assign same_adr = (wr_adr == rd_adr);
  assign rd_word  = mem[rd_adr];

  // Byte-lane write: only enabled lanes change, others keep their stored value.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_adr][i*BYTE_W +: BYTE_W] <= data_in[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  generate
    if (RDW_MODE == 1) begin : g_rdw_new
      // Write-through bypass: enabled lanes of a same-address write replace the stored lanes.
      always_comb begin
        rd_next = rd_word;
        if (wr_go && same_adr) begin
          for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
              rd_next[i*BYTE_W +: BYTE_W] = data_in[i*BYTE_W +: BYTE_W];
            end
          end
        end
      end
    end else begin : g_rdw_old
      // Old-data policy: the array read sees contents before this edge's write.
      always_comb begin
        rd_next = rd_word;
      end
    end
  endgenerate

  // Stage 1: capture on rd_en, valid follows rd_en, data holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= rd_en;
      if (rd_en) begin
        s1_dat <= rd_next;
      end
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic              s2_vld;
      logic [DATA_W-1:0] s2_dat;

      // Stage 2: valid copied every cycle, data only advances behind a valid stage 1.
      always_ff @(posedge clk) begin
        if (reset) begin
          s2_vld <= 1'b0;
          s2_dat <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_dat <= s1_dat;
          end
        end
      end

      assign data_out = s2_dat;
      assign rd_valid = s2_vld;
    end else begin : g_no_out_reg
      assign data_out = s1_dat;
      assign rd_valid = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_dp_mem_be.sv
// Self-checking bench for dp_mem_be: four configurations against a timestamped reference model.
// Three 16-bit instances share inputs (old/new RDW, latency 1/2); a 32-bit x 16 instance runs alongside.
// Inputs are always accepted; outputs are compared every cycle, one time unit after the edge.
module tb_dp_mem_be;

  logic clk;
  logic reset;

  // Shared 16-bit port stimulus
  logic [15:0] din16;
  logic [9:0]  wa16, ra16;
  logic        we16, re16;
  logic [1:0]  be16;

  // Wide instance stimulus
  logic [31:0] dinw;
  logic [3:0]  waw, raw;
  logic        wew, rew;
  logic [3:0]  bew;

  logic [15:0] q0, q1, qp;
  logic [31:0] qw;
  logic        v0, v1, vp, vw;

  int n_checks = 0;
  int n_errors = 0;

  dp_mem_be #(.RDW_MODE(0), .OUT_REG(0)) u_d0 (
    .clk(clk), .reset(reset), .data_in(din16), .wr_adr(wa16), .wr_en(we16), .wr_be(be16),
    .rd_adr(ra16), .rd_en(re16), .data_out(q0), .rd_valid(v0));

  dp_mem_be #(.RDW_MODE(1), .OUT_REG(0)) u_d1 (
    .clk(clk), .reset(reset), .data_in(din16), .wr_adr(wa16), .wr_en(we16), .wr_be(be16),
    .rd_adr(ra16), .rd_en(re16), .data_out(q1), .rd_valid(v1));

  dp_mem_be #(.RDW_MODE(0), .OUT_REG(1)) u_dp (
    .clk(clk), .reset(reset), .data_in(din16), .wr_adr(wa16), .wr_en(we16), .wr_be(be16),
    .rd_adr(ra16), .rd_en(re16), .data_out(qp), .rd_valid(vp));

  dp_mem_be #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8), .RDW_MODE(1), .OUT_REG(1)) u_w (
    .clk(clk), .reset(reset), .data_in(dinw), .wr_adr(waw), .wr_en(wew), .wr_be(bew),
    .rd_adr(raw), .rd_en(rew), .data_out(qw), .rd_valid(vw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Model keeps plain word arrays and, per instance, the read result issued at each edge.
  // Expected output after edge t is the read issued at edge t-latency+1, unless a reset
  // edge happened at or after that issue edge.
  logic [31:0] m16 [1024];
  logic [31:0] mw  [16];
  int          t = 0;
  int          last_rst = -10;
  bit          hv   [4][4];
  logic [31:0] hd   [4][4];
  logic [31:0] held [4];
  bit          ev   [4];

  function automatic int lat_of(input int k);
    return (k >= 2) ? 2 : 1;
  endfunction

  function automatic bit newdata_of(input int k);
    return (k == 1) || (k == 3);
  endfunction

  // Lane-merge: lanes with be set come from nw, the rest from old.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be, input bit use_new);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (use_new && be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic model_edge();
    logic [31:0] r;
    int s;
    t++;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        r = merge(m16[ra16], {16'h0, din16}, {2'b00, be16},
                  newdata_of(k) && !reset && we16 && (wa16 == ra16));
        hv[k][t % 4] = !reset && re16;
      end else begin
        r = merge(mw[raw], dinw, bew, !reset && wew && (waw == raw));
        hv[k][t % 4] = !reset && rew;
      end
      hd[k][t % 4] = r;
    end
    if (!reset && we16) m16[wa16] = merge(m16[wa16], {16'h0, din16}, {2'b00, be16}, 1'b1);
    if (!reset && wew)  mw[waw]   = merge(mw[waw], dinw, bew, 1'b1);
    if (reset) last_rst = t;
    for (int k = 0; k < 4; k++) begin
      s = t - lat_of(k) + 1;
      ev[k] = (s > 0) && hv[k][s % 4] && (last_rst < s);
      if (ev[k]) held[k] = hd[k][s % 4];
      if (reset) held[k] = 32'h0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, t);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("d0_vld", {31'h0, v0}, {31'h0, ev[0]});
    check("d0_dat", {16'h0, q0}, held[0]);
    check("d1_vld", {31'h0, v1}, {31'h0, ev[1]});
    check("d1_dat", {16'h0, q1}, held[1]);
    check("dp_vld", {31'h0, vp}, {31'h0, ev[2]});
    check("dp_dat", {16'h0, qp}, held[2]);
    check("w_vld",  {31'h0, vw}, {31'h0, ev[3]});
    check("w_dat",  qw, held[3]);
  endtask

  task automatic drive16(input bit we, input logic [9:0] wa, input logic [15:0] d,
                         input logic [1:0] be, input bit re, input logic [9:0] ra);
    we16 = we; wa16 = wa; din16 = d; be16 = be; re16 = re; ra16 = ra;
  endtask

  function automatic logic [9:0] pick16();
    int a;
    a = $urandom_range(0, 15);
    return (a < 8) ? 10'(a) : 10'(1008 + a);  // 0..7 and 0x3F8..0x3FF
  endfunction

  initial begin
    reset = 1'b1;
    drive16(0, 0, 0, 0, 0, 0);
    wew = 0; waw = 0; dinw = 0; bew = 0; rew = 0; raw = 0;
    for (int k = 0; k < 4; k++) held[k] = 32'h0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        hv[k][j] = 0; hd[k][j] = 0;
      end

    // Reset: outputs must be zero.
    cycle();
    cycle();
    check("rst_d0_dat", {16'h0, q0}, 32'h0);
    check("rst_w_vld", {31'h0, vw}, 32'h0);
    reset = 1'b0;

    // Define every location so the model never depends on undefined contents.
    for (int i = 0; i < 1024; i++) begin
      drive16(1, 10'(i), 16'($urandom), 2'b11, 0, 0);
      wew = (i < 16); waw = 4'(i); dinw = $urandom; bew = 4'hF;
      cycle();
    end
    wew = 0;

    // Full-word write then read at the top address.
    drive16(1, 10'h3FF, 16'hA5C3, 2'b11, 0, 0); cycle();
    drive16(0, 0, 0, 0, 1, 10'h3FF);            cycle();
    check("fw_dat", {16'h0, q0}, 32'h0000A5C3);
    check("fw_vld", {31'h0, v0}, 32'h1);
    drive16(0, 0, 0, 0, 0, 0);                  cycle();
    check("fw_hold", {16'h0, q0}, 32'h0000A5C3);

    // Byte enables.
    drive16(1, 10'd5, 16'h1234, 2'b11, 0, 0); cycle();
    drive16(1, 10'd5, 16'hABCD, 2'b10, 0, 0); cycle();
    drive16(1, 10'd5, 16'hFFFF, 2'b00, 0, 0); cycle();
    drive16(0, 0, 0, 0, 1, 10'd5);            cycle();
    check("be_dat", {16'h0, q0}, 32'h0000AB34);

    // Read-during-write, same address.
    drive16(1, 10'd7, 16'h0001, 2'b11, 0, 0);      cycle();
    drive16(1, 10'd7, 16'hBEEF, 2'b01, 1, 10'd7);  cycle();
    check("rdw_old", {16'h0, q0}, 32'h00000001);
    check("rdw_new", {16'h0, q1}, 32'h000000EF);
    drive16(0, 0, 0, 0, 1, 10'd7);                 cycle();
    check("rdw_after0", {16'h0, q0}, 32'h000000EF);
    check("rdw_after1", {16'h0, q1}, 32'h000000EF);

    // Pipelined streaming on the latency-2 instance.
    for (int a = 0; a < 8; a++) begin
      drive16(1, 10'(a), 16'(16'h0100 + a), 2'b11, 0, 0); cycle();
    end
    for (int j = 0; j < 8; j++) begin
      drive16(0, 0, 0, 0, 1, 10'(j)); cycle();
      if (j == 0) check("str_first_vld", {31'h0, vp}, 32'h0);
      else begin
        check("str_vld", {31'h0, vp}, 32'h1);
        check("str_dat", {16'h0, qp}, 32'(16'h0100 + j - 1));
      end
    end
    drive16(0, 0, 0, 0, 0, 0); cycle();
    check("str_last", {16'h0, qp}, 32'h00000107);
    cycle();
    check("str_end_vld", {31'h0, vp}, 32'h0);

    // Reset with reads in flight; write during reset must be dropped.
    drive16(0, 0, 0, 0, 1, 10'd0); cycle();
    reset = 1'b1;
    drive16(1, 10'd3, 16'hDEAD, 2'b11, 1, 10'd1); cycle();
    check("mid_rst_vld", {31'h0, vp}, 32'h0);
    check("mid_rst_dat", {16'h0, qp}, 32'h0);
    reset = 1'b0;
    drive16(0, 0, 0, 0, 0, 0); cycle();
    check("mid_rst_drop", {31'h0, vp}, 32'h0);
    drive16(0, 0, 0, 0, 1, 10'd3); cycle();
    drive16(0, 0, 0, 0, 1, 10'd0); cycle();
    check("rst_nowrite", {16'h0, qp}, 32'h00000103);
    drive16(0, 0, 0, 0, 0, 0); cycle();
    check("rst_keep", {16'h0, qp}, 32'h00000100);

    // Randomized traffic on all instances.
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive16($urandom_range(0, 3) != 0, pick16(), 16'($urandom), 2'($urandom),
              $urandom_range(0, 3) != 0, pick16());
      wew = ($urandom_range(0, 3) != 0); waw = 4'($urandom); dinw = $urandom; bew = 4'($urandom);
      rew = ($urandom_range(0, 3) != 0); raw = ($urandom_range(0, 2) == 0) ? waw : 4'($urandom);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dp_mem_be.md
# dp_mem_be

Parametrised simple dual-port RAM: one write port with per-byte enables and one read port with a read enable and a valid flag, both on a single clock. It is the general-purpose on-chip buffer for datapath blocks that need configurable width and depth, a selectable read-during-write policy, and an optional output pipeline register for timing closure. The write and read ports may target any addresses in the same cycle.

## Interface
- DATA_W, 16, word width in bits; must be an integer multiple of BYTE_W.
- ADDR_W, 10, address width; depth = 2**ADDR_W words.
- BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (write-through bypass).
- OUT_REG, 0, 0 = read latency 1; 1 = an extra output register stage, read latency 2.

One clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  write data.
- wr_adr  in  ADDR_W  write address.
- wr_en  in  1  write strobe.
- wr_be  in  NB  byte-lane enables; bit i covers data bits [i*BYTE_W +: BYTE_W].
- rd_adr  in  ADDR_W  read address.
- rd_en  in  1  read strobe.
- data_out  out  DATA_W  read data.
- rd_valid  out  1  data_out carries the result of a read issued 1+OUT_REG cycles earlier.

## Operation
- Write: on an edge with wr_en=1 and reset=0, each lane i with wr_be[i]=1 takes data_in lane i at memory[wr_adr]. Lanes with wr_be[i]=0 keep their value. A write with wr_en=1 and wr_be=0 changes nothing.
- Read: on an edge with rd_en=1 and reset=0, the word at rd_adr is captured into stage 1, and the stage-1 valid bit is set. With rd_en=0, the stage-1 valid bit clears and the stage-1 data holds its value.
- Read-during-write to the same address:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: enabled lanes come from data_in, the other lanes from the stored word.
  - Different addresses never interact.
- OUT_REG=1: stage 2 copies the stage-1 valid bit every cycle. Stage 2 loads the stage-1 data only when the stage-1 valid bit is 1, and holds it otherwise.
- Outputs: data_out and rd_valid come from the last stage. data_out holds the last valid result while rd_valid=0.
- Reset:
  - Clears rd_valid, data_out and all pipeline stages to 0 on the next edge.
  - Discards any in-flight reads; they never produce rd_valid.
  - Writes presented while reset=1 are ignored.
  - Memory contents are not cleared; unwritten locations read as undefined.
- Addresses wrap naturally at the ADDR_W width; there are no out-of-range checks.

## Timing
- Reset values: data_out = 0, rd_valid = 0.
- Read latency:
  - OUT_REG=0: rd_en sampled at edge N gives rd_valid=1 and the data after edge N.
  - OUT_REG=1: the result appears after edge N+1.
- Back-to-back reads on every cycle give one result per cycle, in issue order, with no bubbles.
- Write-to-read visibility: a write at edge N is visible to a read issued at edge N+1 in both modes, and at edge N itself when RDW_MODE=1.
- reset asserted at edge N with reads in flight: rd_valid=0 from after edge N. A read issued at the first edge with reset=0 behaves normally.

## Test plan
- Full-word write then read (defaults): write 16'hA5C3 to address 10'h3FF; read 10'h3FF on the next cycle -> after one edge rd_valid=1 and data_out=16'hA5C3. The previous rd_valid=0 cycle leaves data_out unchanged.
- Byte enables: write 16'h1234 to address 5, then write 16'hABCD with wr_be=2'b10 -> a read of address 5 returns 16'hAB34. A write with wr_be=2'b00 leaves the word unchanged.
- Read-during-write: address 7 holds 16'h0001; in one cycle, write 16'hBEEF with wr_be=2'b01 to address 7 and read address 7.
  - RDW_MODE=0 -> returns 16'h0001.
  - RDW_MODE=1 -> returns 16'h00EF.
  - A following read returns 16'h00EF in both modes.
- Pipelined streaming (OUT_REG=1): fill addresses 0..7 with 16'h0100+addr, then issue reads of 0..7 on consecutive cycles.
  - rd_valid rises exactly 2 cycles after the first rd_en and stays high for 8 cycles.
  - data_out shows 16'h0100..16'h0107 in order.
- Reset mid-stream (OUT_REG=1): assert reset for one cycle while two reads are in flight.
  - rd_valid=0 and data_out=0 after that edge, and neither in-flight read ever appears.
  - Memory contents written before reset still read back correctly.
  - A write with wr_en=1 during reset is not stored.
- Wide configuration: DATA_W=32, BYTE_W=8, ADDR_W=4, with random writes, byte enables and reads checked against a reference model for 2000 cycles, including address wrap at 4'hF and simultaneous same-address and different-address accesses -> zero mismatches.
